// File: rtl/tc_pl_chips_opm_rd_pkg.sv
// Shared types and defaults for the OPM read path: FSM state encoding, default widths
// and SCK divider, and a small sizing helper.
package tc_pl_chips_opm_rd_pkg;

  localparam int unsigned DefCmdW   = 16;
  localparam int unsigned DefRspW   = 16;
  localparam int unsigned DefClkDiv = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StTx,
    StRx,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tc_pl_chips_opm_rd_if.sv
// PS-side register interface of the OPM read path: command write, result, sticky flags.
interface tc_pl_chips_opm_rd_if
  import tc_pl_chips_opm_rd_pkg::*;
#(
  parameter int unsigned AGP0_36 = DefCmdW,
  parameter int unsigned AGP0_37 = DefRspW
);

  logic [AGP0_36-1:0] gp0_r8;
  logic               gp0_r8w;
  logic               gp0_r9c;
  logic [AGP0_37-1:0] gp0_r9;
  logic               gp0_r9v;
  logic               gp0_r9b;
  logic               gp0_r9e;

  modport master (
    output gp0_r8, gp0_r8w, gp0_r9c,
    input  gp0_r9, gp0_r9v, gp0_r9b, gp0_r9e
  );

  modport slave (
    input  gp0_r8, gp0_r8w, gp0_r9c,
    output gp0_r9, gp0_r9v, gp0_r9b, gp0_r9e
  );

endinterface

// File: rtl/tc_pl_chips_sync2.sv
// Two-flop synchroniser for asynchronous single-bit PL chip inputs; resets to 0.
module tc_pl_chips_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/tc_pl_chips_opm_rd.sv
// OPM read path: one SPI-style read per PS command write, result back through gp0_r9.
// Optional feature macro: OPM_RD_PARITY_EN (trailing even-parity bit on the response).
module tc_pl_chips_opm_rd
  import tc_pl_chips_opm_rd_pkg::*;
#(
  parameter int unsigned AGP0_36 = DefCmdW,
  parameter int unsigned AGP0_37 = DefRspW,
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic                 clk125,
  input  logic                 rst,
  tc_pl_chips_opm_rd_if.slave  gp0,
  output logic                 OPM0_CSN,
  output logic                 OPM0_SCK,
  output logic                 OPM0_MOSI,
  input  logic                 OPM0_MISO
);

`ifdef OPM_RD_PARITY_EN
  localparam int unsigned RxBits = AGP0_37 + 1;
`else
  localparam int unsigned RxBits = AGP0_37;
`endif
  localparam int unsigned   BitW      = $clog2(max_u(AGP0_36, AGP0_37) + 1);
  localparam logic [7:0]    PhaseLoad = 8'(CLK_DIV - 1);
  localparam logic [BitW-1:0] TxLast  = BitW'(AGP0_36 - 1);
  localparam logic [BitW-1:0] RxLast  = BitW'(RxBits - 1);

  state_e               state_q, state_d;
  logic [7:0]           phase_q, phase_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [AGP0_36-1:0]   tx_sr_q, tx_sr_d;
  logic [RxBits-1:0]    rx_sr_q, rx_sr_d;
  logic                 csn_q, csn_d, sck_q, sck_d, mosi_q, mosi_d;
  logic                 busy_q;
  logic [AGP0_37-1:0]   r9_q;
  logic                 r9v_q;
  logic                 done;
  logic                 miso_s;
  logic                 phase_end;

  tc_pl_chips_sync2 u_sync_miso (
    .clk (clk125),
    .rst (rst),
    .d   (OPM0_MISO),
    .q   (miso_s)
  );

  assign phase_end = (phase_q == 8'd0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    csn_d   = csn_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gp0.gp0_r8w) begin
          state_d = StSetup;
          phase_d = PhaseLoad;
          tx_sr_d = gp0.gp0_r8;
          csn_d   = 1'b0;
          mosi_d  = gp0.gp0_r8[AGP0_36-1];
        end
      end
      StSetup: begin
        if (phase_end) begin
          state_d = StTx;
          phase_d = PhaseLoad;
          bit_d   = '0;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StTx, StRx: begin
        if (!phase_end) begin
          phase_d = phase_q - 8'd1;
        end else if (!sck_q) begin
          sck_d   = 1'b1;
          phase_d = PhaseLoad;
        end else begin
          // Last cycle of the high phase: sample MISO, then open the next low phase.
          sck_d   = 1'b0;
          phase_d = PhaseLoad;
          if (state_q == StTx) begin
            if (bit_q == TxLast) begin
              state_d = StRx;
              bit_d   = '0;
              mosi_d  = 1'b0;
            end else begin
              bit_d   = bit_q + BitW'(1);
              tx_sr_d = tx_sr_q << 1;
              mosi_d  = tx_sr_q[AGP0_36-2];
            end
          end else begin
            rx_sr_d = {rx_sr_q[RxBits-2:0], miso_s};
            if (bit_q == RxLast) begin
              state_d = StHold;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StGap;
          phase_d = PhaseLoad;
          csn_d   = 1'b1;
          done    = 1'b1;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StGap: begin
        if (phase_end) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Result registers; a completion in the same cycle as a clear keeps the flag set.
`ifdef OPM_RD_PARITY_EN
  logic r9e_q;

  always_ff @(posedge clk125) begin
    if (rst) begin
      r9_q  <= '0;
      r9v_q <= 1'b0;
      r9e_q <= 1'b0;
    end else begin
      if (done) r9_q <= rx_sr_q[RxBits-1:1];
      r9v_q <= done | (r9v_q & ~gp0.gp0_r9c);
      r9e_q <= (done & (^rx_sr_q)) | (r9e_q & ~gp0.gp0_r9c);
    end
  end

  assign gp0.gp0_r9e = r9e_q;
`else
  always_ff @(posedge clk125) begin
    if (rst) begin
      r9_q  <= '0;
      r9v_q <= 1'b0;
    end else begin
      if (done) r9_q <= rx_sr_q;
      r9v_q <= done | (r9v_q & ~gp0.gp0_r9c);
    end
  end

  assign gp0.gp0_r9e = 1'b0;
`endif

  assign gp0.gp0_r9  = r9_q;
  assign gp0.gp0_r9v = r9v_q;
  assign gp0.gp0_r9b = busy_q;
  assign OPM0_CSN    = csn_q;
  assign OPM0_SCK    = sck_q;
  assign OPM0_MOSI   = mosi_q;

endmodule
